multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
Parametrised next-generation multicycle RV32I control FSM. It drives the same datapath controls as the current unit (PC, IR, memory, ALU muxes, register write) and extends them with:
- a ready/valid memory handshake with optional wait-state timeout;
- an optional multi-cycle M-extension execute path;
- trap generation for illegal, ECALL/EBREAK and bus-error conditions;
- FENCE-as-NOP;
- a retire pulse.

It sits between the instruction register / opcode decode and the multicycle datapath.

Parameters:
MEM_HANDSHAKE, 1, 1: memory accesses wait for mem_ready; 0: mem_ready ignored, every access completes in one cycle.
WAIT_TIMEOUT, 16, cycles to wait for mem_ready before a bus-error trap; 0 disables the timeout.
ENABLE_MULDIV, 1, 1: RTYPE with funct7_m=1 uses the EXECUTEM path; 0: such instructions trap as illegal.
TIMER_WIDTH, 8, width of the wait counter; must hold WAIT_TIMEOUT.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
instruction_opcode  in  7  opcode field of IR
funct7_m  in  1  IR[25], selects M-extension for RTYPE
funct12_ebreak  in  1  IR[20], distinguishes EBREAK from ECALL
mem_ready  in  1  memory completes the current read/write this cycle
muldiv_done  in  1  multiply/divide unit result valid
pc_write_cond, pc_write, lorD, memory_read, memory_write, memory_to_reg, ir_write, is_immediate, reg_write  out  1 each  datapath controls, same meaning as the current unit
pc_source  out  2  00 ALU, 01 ALU-out/branch target, 10 trap vector
aluop  out  2  00 add, 01 branch compare, 10 funct decode, 11 muldiv
alu_src_a  out  2  00 PC, 01 rs1, 10 zero
alu_src_b  out  2  00 rs2, 01 const 4, 10 immediate
muldiv_start  out  1  one-cycle start pulse to the muldiv unit
trap  out  1  trap taken this cycle
trap_cause  out  2  00 illegal, 01 ECALL, 10 EBREAK, 11 bus error
instr_retired  out  1  one-cycle pulse on an instruction's final cycle

Behaviour:
- Reset: while reset=0, all outputs are forced to 0 combinationally. At the clock edge with reset=0, state<=FETCH, wait counter<=0, muldiv start flag cleared. Reset mid-wait or mid-muldiv abandons the operation, with no write and no retire.
- State encoding is 5-bit: FETCH, DECODE, JALR_ADDR, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, EXECUTEM, ALUWB, JAL, JALR, BRANCH, AUIPC, LUI, TRAP.
- Outputs default to 0 and are Moore-decoded from state, except where qualified by mem_ready below.
- Let rdy = mem_ready | ~MEM_HANDSHAKE.
- FETCH:
  - memory_read=1, alu_src_b=01.
  - ir_write and pc_write are asserted only when rdy.
  - Stay in FETCH while !rdy.
  - On rdy: go to JALR_ADDR if opcode==1100111, else DECODE.
- DECODE (alu_src_b=10), transitions by opcode:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECUTEM if funct7_m && ENABLE_MULDIV, else EXECUTER if !funct7_m, else TRAP(illegal)
  - 0010011 -> EXECUTEI
  - 1101111 -> JAL
  - 1100011 -> BRANCH
  - 0010111 -> AUIPC
  - 0110111 -> LUI
  - 0001111 -> FETCH, with instr_retired=1
  - 1110011 -> TRAP, cause 10 if funct12_ebreak else 01
  - any other opcode -> TRAP(illegal)
- JALR_ADDR:
  - alu_src_a=01, alu_src_b=10; -> JALR.
- JALR:
  - alu_src_a=00, alu_src_b=01, pc_write=1, pc_source=01, is_immediate=1; -> ALUWB.
- MEMADR:
  - alu_src_a=01, alu_src_b=10.
  - -> MEMREAD for a load, MEMWRITE for a store.
- MEMREAD:
  - memory_read=1, lorD=1.
  - Wait for rdy, then -> MEMWB.
- MEMWB:
  - reg_write=1, memory_to_reg=1, instr_retired=1; -> FETCH.
- MEMWRITE:
  - memory_write=1, lorD=1.
  - On rdy: instr_retired=1, -> FETCH.
- EXECUTER:
  - alu_src_a=01, aluop=10; -> ALUWB.
- EXECUTEI:
  - alu_src_a=01, alu_src_b=10, aluop=10, is_immediate=1; -> ALUWB.
- EXECUTEM:
  - alu_src_a=01, aluop=11.
  - muldiv_start=1 on the first cycle in the state only.
  - Hold until muldiv_done, then -> ALUWB. No timeout applies.
  - muldiv_done already high on the first cycle -> ALUWB on the next edge.
- ALUWB:
  - reg_write=1, instr_retired=1; -> FETCH.
- JAL:
  - alu_src_a=00, alu_src_b=01, pc_write=1, pc_source=01; -> ALUWB.
- BRANCH:
  - alu_src_a=01, aluop=01, pc_write_cond=1, pc_source=01, instr_retired=1; -> FETCH.
- AUIPC:
  - alu_src_b=10; -> ALUWB.
- LUI:
  - alu_src_a=10, alu_src_b=10; -> ALUWB.
- TRAP:
  - trap=1, trap_cause held from the registered cause, pc_write=1, pc_source=10; one cycle, -> FETCH.
  - No reg_write; instr_retired=0.
- Wait counter:
  - Increments each cycle in FETCH, MEMREAD or MEMWRITE while !rdy; clears on any state change.
  - If WAIT_TIMEOUT!=0 and counter==WAIT_TIMEOUT-1 with !rdy: -> TRAP with cause 11, and no ir_write, reg_write or memory_write side-effect.
  - mem_ready arriving on the timeout cycle wins: the access completes, no trap.
  - The counter saturates and never wraps.
- Undefined state encodings -> FETCH.

Decomposition:
- Shared package: opcode constants (existing plus FENCE 0001111, SYSTEM 1110011), state enum, trap_cause codes, pc_source / aluop / alu_src encodings.
- One natural sub-module: mem_wait_timer, holding the counter, the saturate logic and the timeout flag, parametrised by TIMER_WIDTH and WAIT_TIMEOUT.

Test Plan:
- ADDI (0010011), mem_ready=1 every cycle -> states FETCH, DECODE, EXECUTEI, ALUWB; reg_write and instr_retired pulse in cycle 4.
- LW with mem_ready held low 3 cycles in MEMREAD -> MEMREAD lasts 4 cycles; MEMWB reg_write=1, memory_to_reg=1; no trap.
- Fetch with mem_ready=0 for 16 cycles (WAIT_TIMEOUT=16) -> trap=1, trap_cause=11, pc_source=10, ir_write never 1.
- MUL (0110011, funct7_m=1), muldiv_done after 5 cycles -> muldiv_start high exactly 1 cycle; aluop=11; ALUWB follows done. With ENABLE_MULDIV=0 -> TRAP, cause 00.
- Opcode 1110011 with funct12_ebreak=1 -> TRAP, cause 10. Opcode 0000000 -> cause 00. FENCE -> back to FETCH after DECODE with instr_retired=1.
- Reset driven low during the EXECUTEM wait -> all outputs 0 immediately; FETCH after release; muldiv_start re-pulses only for a fresh instruction.

Source files
------------

// File: rtl/multicycle_control_unit_pkg.sv
// Shared opcodes, FSM states and datapath select encodings for the multicycle RV32I control unit.
package multicycle_control_unit_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [4:0] {
        S_FETCH     = 5'd0,
        S_DECODE    = 5'd1,
        S_JALR_ADDR = 5'd2,
        S_MEMADR    = 5'd3,
        S_MEMREAD   = 5'd4,
        S_MEMWB     = 5'd5,
        S_MEMWRITE  = 5'd6,
        S_EXECUTER  = 5'd7,
        S_EXECUTEI  = 5'd8,
        S_EXECUTEM  = 5'd9,
        S_ALUWB     = 5'd10,
        S_JAL       = 5'd11,
        S_JALR      = 5'd12,
        S_BRANCH    = 5'd13,
        S_AUIPC     = 5'd14,
        S_LUI       = 5'd15,
        S_TRAP      = 5'd16
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_ILLEGAL = 2'b00,
        CAUSE_ECALL   = 2'b01,
        CAUSE_EBREAK  = 2'b10,
        CAUSE_BUS_ERR = 2'b11
    } trap_cause_t;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_TRAP   = 2'b10;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT  = 2'b10;
    localparam logic [1:0] ALUOP_MULDIV = 2'b11;

    localparam logic [1:0] SRC_A_PC   = 2'b00;
    localparam logic [1:0] SRC_A_RS1  = 2'b01;
    localparam logic [1:0] SRC_A_ZERO = 2'b10;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_FOUR = 2'b01;
    localparam logic [1:0] SRC_B_IMM  = 2'b10;

endpackage

// File: rtl/multicycle_control_unit_mem_wait_timer.sv
// Saturating wait-state counter; flags the last cycle a memory access may stall before a bus error.
module multicycle_control_unit_mem_wait_timer #(
    parameter int unsigned TIMER_WIDTH  = 8,
    parameter int unsigned WAIT_TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic count_en,
    input  logic clear,
    output logic timeout
);

    localparam logic [TIMER_WIDTH-1:0] LIMIT =
        TIMER_WIDTH'((WAIT_TIMEOUT == 0) ? 0 : WAIT_TIMEOUT - 1);

    logic [TIMER_WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_en && (count != '1)) begin
            count <= count + TIMER_WIDTH'(1);
        end
    end

    assign timeout = (WAIT_TIMEOUT != 0) && count_en && (count == LIMIT);

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I control FSM with memory handshake, optional M-extension path, traps and retire pulse.
module multicycle_control_unit
    import multicycle_control_unit_pkg::*;
#(
    parameter bit          MEM_HANDSHAKE = 1'b1,
    parameter int unsigned WAIT_TIMEOUT  = 16,
    parameter bit          ENABLE_MULDIV = 1'b1,
    parameter int unsigned TIMER_WIDTH   = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] instruction_opcode,
    input  logic       funct7_m,
    input  logic       funct12_ebreak,
    input  logic       mem_ready,
    input  logic       muldiv_done,
    output logic       pc_write_cond,
    output logic       pc_write,
    output logic       lorD,
    output logic       memory_read,
    output logic       memory_write,
    output logic       memory_to_reg,
    output logic       ir_write,
    output logic       is_immediate,
    output logic       reg_write,
    output logic [1:0] pc_source,
    output logic [1:0] aluop,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       muldiv_start,
    output logic       trap,
    output logic [1:0] trap_cause,
    output logic       instr_retired
);

    state_t      state, next_state;
    trap_cause_t cause_q, next_cause;
    logic        md_started;
    logic        rdy, wait_en, timeout;

    assign rdy     = mem_ready || !MEM_HANDSHAKE;
    assign wait_en = reset && !rdy &&
                     (state == S_FETCH || state == S_MEMREAD || state == S_MEMWRITE);

    multicycle_control_unit_mem_wait_timer #(
        .TIMER_WIDTH (TIMER_WIDTH),
        .WAIT_TIMEOUT(WAIT_TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .count_en(wait_en),
        .clear   (next_state != state),
        .timeout (timeout)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_FETCH;
            cause_q    <= CAUSE_ILLEGAL;
            md_started <= 1'b0;
        end else begin
            state      <= next_state;
            cause_q    <= next_cause;
            md_started <= (state == S_EXECUTEM) && (next_state == S_EXECUTEM);
        end
    end

    always_comb begin
        next_state    = S_FETCH;
        next_cause    = cause_q;
        pc_write_cond = 1'b0;
        pc_write      = 1'b0;
        lorD          = 1'b0;
        memory_read   = 1'b0;
        memory_write  = 1'b0;
        memory_to_reg = 1'b0;
        ir_write      = 1'b0;
        is_immediate  = 1'b0;
        reg_write     = 1'b0;
        pc_source     = PC_SRC_ALU;
        aluop         = ALUOP_ADD;
        alu_src_a     = SRC_A_PC;
        alu_src_b     = SRC_B_RS2;
        muldiv_start  = 1'b0;
        trap          = 1'b0;
        trap_cause    = 2'b00;
        instr_retired = 1'b0;
        // While reset is low every output stays at its zero default.
        if (reset) begin
            case (state)
                S_FETCH: begin
                    memory_read = 1'b1;
                    alu_src_b   = SRC_B_FOUR;
                    next_state  = S_FETCH;
                    if (rdy) begin
                        ir_write   = 1'b1;
                        pc_write   = 1'b1;
                        next_state = (instruction_opcode == OP_JALR) ? S_JALR_ADDR : S_DECODE;
                    end else if (timeout) begin
                        next_state = S_TRAP;
                        next_cause = CAUSE_BUS_ERR;
                    end
                end
                S_DECODE: begin
                    alu_src_b  = SRC_B_IMM;
                    next_state = S_TRAP;
                    next_cause = CAUSE_ILLEGAL;
                    case (instruction_opcode)
                        OP_LOAD, OP_STORE: next_state = S_MEMADR;
                        OP_RTYPE: begin
                            if (funct7_m && ENABLE_MULDIV) next_state = S_EXECUTEM;
                            else if (!funct7_m)            next_state = S_EXECUTER;
                        end
                        OP_ITYPE:  next_state = S_EXECUTEI;
                        OP_JAL:    next_state = S_JAL;
                        OP_BRANCH: next_state = S_BRANCH;
                        OP_AUIPC:  next_state = S_AUIPC;
                        OP_LUI:    next_state = S_LUI;
                        OP_FENCE: begin
                            next_state    = S_FETCH;
                            instr_retired = 1'b1;
                        end
                        OP_SYSTEM: next_cause = funct12_ebreak ? CAUSE_EBREAK : CAUSE_ECALL;
                        default: ;
                    endcase
                end
                S_JALR_ADDR: begin
                    alu_src_a  = SRC_A_RS1;
                    alu_src_b  = SRC_B_IMM;
                    next_state = S_JALR;
                end
                S_JALR: begin
                    alu_src_b    = SRC_B_FOUR;
                    pc_write     = 1'b1;
                    pc_source    = PC_SRC_ALUOUT;
                    is_immediate = 1'b1;
                    next_state   = S_ALUWB;
                end
                S_MEMADR: begin
                    alu_src_a  = SRC_A_RS1;
                    alu_src_b  = SRC_B_IMM;
                    next_state = (instruction_opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
                end
                S_MEMREAD: begin
                    memory_read = 1'b1;
                    lorD        = 1'b1;
                    next_state  = S_MEMREAD;
                    if (rdy) begin
                        next_state = S_MEMWB;
                    end else if (timeout) begin
                        next_state = S_TRAP;
                        next_cause = CAUSE_BUS_ERR;
                    end
                end
                S_MEMWB: begin
                    reg_write     = 1'b1;
                    memory_to_reg = 1'b1;
                    instr_retired = 1'b1;
                end
                S_MEMWRITE: begin
                    memory_write = 1'b1;
                    lorD         = 1'b1;
                    next_state   = S_MEMWRITE;
                    if (rdy) begin
                        instr_retired = 1'b1;
                        next_state    = S_FETCH;
                    end else if (timeout) begin
                        next_state = S_TRAP;
                        next_cause = CAUSE_BUS_ERR;
                    end
                end
                S_EXECUTER: begin
                    alu_src_a  = SRC_A_RS1;
                    aluop      = ALUOP_FUNCT;
                    next_state = S_ALUWB;
                end
                S_EXECUTEI: begin
                    alu_src_a    = SRC_A_RS1;
                    alu_src_b    = SRC_B_IMM;
                    aluop        = ALUOP_FUNCT;
                    is_immediate = 1'b1;
                    next_state   = S_ALUWB;
                end
                S_EXECUTEM: begin
                    alu_src_a    = SRC_A_RS1;
                    aluop        = ALUOP_MULDIV;
                    muldiv_start = !md_started;
                    next_state   = muldiv_done ? S_ALUWB : S_EXECUTEM;
                end
                S_ALUWB: begin
                    reg_write     = 1'b1;
                    instr_retired = 1'b1;
                end
                S_JAL: begin
                    alu_src_b  = SRC_B_FOUR;
                    pc_write   = 1'b1;
                    pc_source  = PC_SRC_ALUOUT;
                    next_state = S_ALUWB;
                end
                S_BRANCH: begin
                    alu_src_a     = SRC_A_RS1;
                    aluop         = ALUOP_BRANCH;
                    pc_write_cond = 1'b1;
                    pc_source     = PC_SRC_ALUOUT;
                    instr_retired = 1'b1;
                end
                S_AUIPC: begin
                    alu_src_b  = SRC_B_IMM;
                    next_state = S_ALUWB;
                end
                S_LUI: begin
                    alu_src_a  = SRC_A_ZERO;
                    alu_src_b  = SRC_B_IMM;
                    next_state = S_ALUWB;
                end
                S_TRAP: begin
                    trap       = 1'b1;
                    trap_cause = cause_q;
                    pc_write   = 1'b1;
                    pc_source  = PC_SRC_TRAP;
                end
                default: next_state = S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed trace bench: each instruction is expanded into per-cycle expected control words, checked every cycle.
module tb_multicycle_control_unit;

    typedef struct packed {
        logic       pcwc, pcw, lord, mrd, mwr, m2r, irw, imm, rw;
        logic [1:0] pcs, aluop, sa, sb;
        logic       mds, trap;
        logic [1:0] cause;
        logic       ret;
    } out_t;

    typedef struct packed {
        logic        rst;
        logic [6:0]  op;
        logic        f7, eb, mr, md, sel2, pin;
        logic [1:0]  pin_cause, pin_pcs;
        out_t        exp;
        logic [95:0] tag;
    } cyc_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [6:0] op = '0;
    logic       f7 = 1'b0, eb = 1'b0, mr = 1'b0, md = 1'b0;

    logic       a_pcwc, a_pcw, a_lord, a_mrd, a_mwr, a_m2r, a_irw, a_imm, a_rw, a_mds, a_trap, a_ret;
    logic [1:0] a_pcs, a_aluop, a_sa, a_sb, a_cause;
    logic       b_pcwc, b_pcw, b_lord, b_mrd, b_mwr, b_m2r, b_irw, b_imm, b_rw, b_mds, b_trap, b_ret;
    logic [1:0] b_pcs, b_aluop, b_sa, b_sb, b_cause;
    out_t       o1, o2;

    always #5 clk = ~clk;

    multicycle_control_unit #(
        .MEM_HANDSHAKE(1'b1), .WAIT_TIMEOUT(16), .ENABLE_MULDIV(1'b1), .TIMER_WIDTH(8)
    ) dut (
        .clk(clk), .reset(reset), .instruction_opcode(op), .funct7_m(f7), .funct12_ebreak(eb),
        .mem_ready(mr), .muldiv_done(md),
        .pc_write_cond(a_pcwc), .pc_write(a_pcw), .lorD(a_lord), .memory_read(a_mrd),
        .memory_write(a_mwr), .memory_to_reg(a_m2r), .ir_write(a_irw), .is_immediate(a_imm),
        .reg_write(a_rw), .pc_source(a_pcs), .aluop(a_aluop), .alu_src_a(a_sa), .alu_src_b(a_sb),
        .muldiv_start(a_mds), .trap(a_trap), .trap_cause(a_cause), .instr_retired(a_ret)
    );

    multicycle_control_unit #(
        .MEM_HANDSHAKE(1'b1), .WAIT_TIMEOUT(16), .ENABLE_MULDIV(1'b0), .TIMER_WIDTH(8)
    ) dut_nomd (
        .clk(clk), .reset(reset), .instruction_opcode(op), .funct7_m(f7), .funct12_ebreak(eb),
        .mem_ready(mr), .muldiv_done(md),
        .pc_write_cond(b_pcwc), .pc_write(b_pcw), .lorD(b_lord), .memory_read(b_mrd),
        .memory_write(b_mwr), .memory_to_reg(b_m2r), .ir_write(b_irw), .is_immediate(b_imm),
        .reg_write(b_rw), .pc_source(b_pcs), .aluop(b_aluop), .alu_src_a(b_sa), .alu_src_b(b_sb),
        .muldiv_start(b_mds), .trap(b_trap), .trap_cause(b_cause), .instr_retired(b_ret)
    );

    assign o1 = {a_pcwc, a_pcw, a_lord, a_mrd, a_mwr, a_m2r, a_irw, a_imm, a_rw,
                 a_pcs, a_aluop, a_sa, a_sb, a_mds, a_trap, a_cause, a_ret};
    assign o2 = {b_pcwc, b_pcw, b_lord, b_mrd, b_mwr, b_m2r, b_irw, b_imm, b_rw,
                 b_pcs, b_aluop, b_sa, b_sb, b_mds, b_trap, b_cause, b_ret};

    cyc_t        q[$];
    logic        cur_rst = 1'b0, cur_f7 = 1'b0, cur_eb = 1'b0, cur_sel2 = 1'b0;
    logic [6:0]  cur_op = '0;
    logic [95:0] cur_tag = '0;
    int          checks = 0;
    int          failures = 0;

    task automatic push(input logic mr_v, input logic md_v, input out_t e);
        cyc_t c;
        c = '0;
        c.rst = cur_rst; c.op = cur_op; c.f7 = cur_f7; c.eb = cur_eb;
        c.mr = mr_v; c.md = md_v; c.sel2 = cur_sel2; c.exp = e; c.tag = cur_tag;
        q.push_back(c);
    endtask

    task automatic start(input logic [95:0] tag, input logic [6:0] o, input logic f, input logic b);
        cur_tag = tag; cur_op = o; cur_f7 = f; cur_eb = b;
    endtask

    task automatic reset_cycles(input int n);
        cur_rst = 1'b0;
        for (int i = 0; i < n; i++) push(1'b1, 1'b1, '0);
        cur_rst = 1'b1;
    endtask

    // Trap cycle; cause and pc_source are additionally pinned to hand-written literals.
    task automatic trap_cycle(input logic [1:0] cause, input logic [1:0] lit_cause);
        out_t e;
        cyc_t c;
        e = '0; e.trap = 1'b1; e.cause = cause; e.pcw = 1'b1; e.pcs = 2'b10;
        push(1'b0, 1'b0, e);
        c = q.pop_back();
        c.pin = 1'b1; c.pin_cause = lit_cause; c.pin_pcs = 2'b10;
        q.push_back(c);
    endtask

    task automatic fetch(input int waits, input bit times_out);
        out_t e;
        e = '0; e.mrd = 1'b1; e.sb = 2'b01;
        for (int i = 0; i < waits; i++) push(1'b0, 1'b0, e);
        if (times_out) begin
            trap_cycle(2'b11, 2'b11);
        end else begin
            e.irw = 1'b1; e.pcw = 1'b1;
            push(1'b1, 1'b0, e);
        end
    endtask

    task automatic decode(input bit is_fence);
        out_t e;
        e = '0; e.sb = 2'b10; e.ret = is_fence;
        push(1'b1, 1'b0, e);
    endtask

    task automatic writeback();
        out_t e;
        e = '0; e.rw = 1'b1; e.ret = 1'b1;
        push(1'b1, 1'b0, e);
    endtask

    task automatic one(input out_t e);
        push(1'b1, 1'b0, e);
    endtask

    task automatic alu_instr(input logic [95:0] tag, input logic [6:0] o, input out_t ex);
        start(tag, o, 1'b0, 1'b0);
        fetch(0, 0); decode(0); one(ex); writeback();
    endtask

    task automatic load(input int fwaits, input int rwaits, input bit times_out);
        out_t e;
        fetch(fwaits, 0); decode(0);
        e = '0; e.sa = 2'b01; e.sb = 2'b10; one(e);
        e = '0; e.mrd = 1'b1; e.lord = 1'b1;
        for (int i = 0; i < rwaits; i++) push(1'b0, 1'b0, e);
        if (times_out) begin
            trap_cycle(2'b11, 2'b11);
            return;
        end
        push(1'b1, 1'b0, e);
        e = '0; e.rw = 1'b1; e.m2r = 1'b1; e.ret = 1'b1; one(e);
    endtask

    task automatic store(input int wwaits);
        out_t e;
        fetch(0, 0); decode(0);
        e = '0; e.sa = 2'b01; e.sb = 2'b10; one(e);
        e = '0; e.mwr = 1'b1; e.lord = 1'b1;
        for (int i = 0; i < wwaits; i++) push(1'b0, 1'b0, e);
        e.ret = 1'b1;
        push(1'b1, 1'b0, e);
    endtask

    // n execute cycles; done is raised on the n-th, start only on the first.
    task automatic mul_body(input int n, input bit finish);
        out_t e;
        for (int i = 1; i <= n; i++) begin
            e = '0; e.sa = 2'b01; e.aluop = 2'b11; e.mds = (i == 1);
            push(1'b1, finish && (i == n), e);
        end
        if (finish) writeback();
    endtask

    task automatic build();
        out_t e;
        reset_cycles(2);

        e = '0; e.sa = 2'b01; e.sb = 2'b10; e.aluop = 2'b10; e.imm = 1'b1;
        alu_instr("ADDI", 7'b0010011, e);
        e = '0; e.sa = 2'b01; e.aluop = 2'b10;
        alu_instr("ADD", 7'b0110011, e);

        start("LW_W3", 7'b0000011, 0, 0);  load(0, 3, 0);
        start("SW_W2", 7'b0100011, 0, 0);  store(2);
        start("LW_F15", 7'b0000011, 0, 0); load(15, 0, 0);
        start("FETCH_TO", 7'b0010011, 0, 0); fetch(16, 1);
        start("LW_TO", 7'b0000011, 0, 0);  load(0, 16, 1);

        start("MUL5", 7'b0110011, 1, 0); fetch(0, 0); decode(0); mul_body(5, 1);
        start("MUL1", 7'b0110011, 1, 0); fetch(0, 0); decode(0); mul_body(1, 1);

        e = '0; e.sb = 2'b01; e.pcw = 1'b1; e.pcs = 2'b01;
        alu_instr("JAL", 7'b1101111, e);

        start("JALR", 7'b1100111, 0, 0); fetch(0, 0);
        e = '0; e.sa = 2'b01; e.sb = 2'b10; one(e);
        e = '0; e.sb = 2'b01; e.pcw = 1'b1; e.pcs = 2'b01; e.imm = 1'b1; one(e);
        writeback();

        start("BRANCH", 7'b1100011, 0, 0); fetch(0, 0); decode(0);
        e = '0; e.sa = 2'b01; e.aluop = 2'b01; e.pcwc = 1'b1; e.pcs = 2'b01; e.ret = 1'b1; one(e);

        e = '0; e.sb = 2'b10;
        alu_instr("AUIPC", 7'b0010111, e);
        e = '0; e.sa = 2'b10; e.sb = 2'b10;
        alu_instr("LUI", 7'b0110111, e);

        start("FENCE", 7'b0001111, 0, 0);   fetch(0, 0); decode(1);
        start("ECALL", 7'b1110011, 0, 0);   fetch(0, 0); decode(0); trap_cycle(2'b01, 2'b01);
        start("EBREAK", 7'b1110011, 0, 1);  fetch(0, 0); decode(0); trap_cycle(2'b10, 2'b10);
        start("ILLEGAL", 7'b0000000, 0, 0); fetch(0, 0); decode(0); trap_cycle(2'b00, 2'b00);

        start("RST_MUL", 7'b0110011, 1, 0); fetch(0, 0); decode(0); mul_body(3, 0);
        reset_cycles(2);
        e = '0; e.sa = 2'b01; e.sb = 2'b10; e.aluop = 2'b10; e.imm = 1'b1;
        alu_instr("POST_RST", 7'b0010011, e);
        start("MUL2", 7'b0110011, 1, 0); fetch(0, 0); decode(0); mul_body(2, 1);

        reset_cycles(1);
        cur_sel2 = 1'b1;
        start("NOMD_MUL", 7'b0110011, 1, 0); fetch(0, 0); decode(0); trap_cycle(2'b00, 2'b00);
        e = '0; e.sa = 2'b01; e.aluop = 2'b10;
        alu_instr("NOMD_ADD", 7'b0110011, e);
        cur_sel2 = 1'b0;
        reset_cycles(1);
    endtask

    initial begin
        cyc_t c;
        out_t act;
        build();
        for (int i = 0; i < q.size(); i++) begin
            c = q[i];
            @(posedge clk);
            #1;
            reset = c.rst; op = c.op; f7 = c.f7; eb = c.eb; mr = c.mr; md = c.md;
            @(negedge clk);
            act = c.sel2 ? o2 : o1;
            checks++;
            if (act !== c.exp) begin
                failures++;
                $display("FAIL %0s cycle %0d: outputs got %h expected %h", c.tag, i, act, c.exp);
            end
            if (c.pin) begin
                checks++;
                if (act.cause !== c.pin_cause || act.pcs !== c.pin_pcs) begin
                    failures++;
                    $display("FAIL %0s_pin cycle %0d: cause/pc_source got %b/%b expected %b/%b",
                             c.tag, i, act.cause, act.pcs, c.pin_cause, c.pin_pcs);
                end
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
